// File: rtl/sp_ram_pkg.sv
// Shared types and constants for the synchronous single-port RAM.
package sp_ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ram_state_e;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam int MAX_RD_LATENCY = 4;

endpackage

// File: rtl/ram_rd_pipe.sv
// Read response pipeline: RD_LATENCY-deep valid/data shift register.
// Latency: RD_LATENCY cycles from in_vld to rsp_valid.
// Backpressure: none; every read entering the pipe produces a response.
module ram_rd_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_dat,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [RD_LATENCY-1:0] vld_sr;
    logic [DATA_WIDTH-1:0] dat_sr [RD_LATENCY];

    // Data stages only load on a valid beat, so the last stage holds the previous result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_sr <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                dat_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= in_vld;
            if (in_vld) begin
                dat_sr[0] <= in_dat;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                if (vld_sr[i-1]) begin
                    dat_sr[i] <= dat_sr[i-1];
                end
            end
        end
    end

    assign rsp_valid = vld_sr[RD_LATENCY-1];
    assign data_out  = dat_sr[RD_LATENCY-1];

endmodule

// File: rtl/sp_ram_sync.sv
// Single-port synchronous RAM with byte enables, valid/ready requests and a clear engine.
// Latency: reads return RD_LATENCY cycles after acceptance; writes produce no response.
// Backpressure: req_ready is low while clearing or when clr_req is asserted.
module sp_ram_sync
    import sp_ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int                   BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  rdn_wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [BE_WIDTH-1:0]   wbe,
    input  logic                  clr_req,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rsp_valid,
    output logic                  init_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("sp_ram_sync: DATA_WIDTH must be a multiple of 8");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
        $error("sp_ram_sync: RD_LATENCY must be in 1..4");
    end

    ram_state_e            state;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_raw;
    logic                  req_acc;
    logic                  wr_en;
    logic                  rd_en;
    logic                  clr_we;

    assign req_ready = (state == IDLE) && !clr_req;
    assign req_acc   = req_valid && req_ready;
    assign wr_en     = req_acc && (rdn_wr == OP_WR);
    assign rd_en     = req_acc && (rdn_wr == OP_RD);
    assign clr_we    = (state == CLEAR);
    assign init_busy = (state == CLEAR);
    assign rd_raw    = mem[addr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                    end
                end
            endcase
        end
    end

    // The clear engine and request writes never overlap: req_ready is low throughout CLEAR.
    always_ff @(posedge clk) begin
        if (rst_n && clr_we) begin
            mem[clr_ptr] <= INIT_VALUE;
        end else if (wr_en) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (wbe[i]) begin
                    mem[addr][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (rd_en),
        .in_dat    (rd_raw),
        .rsp_valid (rsp_valid),
        .data_out  (data_out)
    );

    a_rdn_wr_known: assert property (@(posedge clk) disable iff (!rst_n)
        (req_valid && req_ready) |-> !$isunknown(rdn_wr))
        else $error("sp_ram_sync: rdn_wr is X on an accepted request");

endmodule

// File: tb/tb_sp_ram_sync.sv
// Directed bench for sp_ram_sync: clear timing, byte enables, read latency, pipelining, clear collisions.
module tb_sp_ram_sync;

    localparam int          AW   = 4;
    localparam int          DW   = 32;
    localparam int          BW   = 4;
    localparam int          LAT  = 3;
    localparam logic [31:0] INIT = 32'hA5A5A5A5;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          req_valid = 1'b0;
    logic          rdn_wr    = 1'b0;
    logic          clr_req   = 1'b0;
    logic [AW-1:0] addr      = '0;
    logic [DW-1:0] data_in   = '0;
    logic [BW-1:0] wbe       = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic          init_busy;
    logic [DW-1:0] data_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sp_ram_sync #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LATENCY (LAT),
        .INIT_VALUE (INIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rdn_wr    (rdn_wr),
        .addr      (addr),
        .data_in   (data_in),
        .wbe       (wbe),
        .clr_req   (clr_req),
        .data_out  (data_out),
        .rsp_valid (rsp_valid),
        .init_busy (init_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All drivers change inputs at the falling edge; outputs are sampled there too.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        req_valid = 1'b1; rdn_wr = 1'b1; addr = a; data_in = d; wbe = be;
        @(negedge clk);
        req_valid = 1'b0; rdn_wr = 1'b0; wbe = '0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
        req_valid = 1'b1; rdn_wr = 1'b0; addr = a;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        d = data_out;
    endtask

    // Counts cycles with init_busy high; mid_pulse >= 0 injects a clr_req at that cycle.
    task automatic count_busy(input int mid_pulse, output int n, output logic ready_seen);
        n = 0;
        ready_seen = 1'b0;
        while (init_busy && n < 100) begin
            if (req_ready) ready_seen = 1'b1;
            clr_req = (n == mid_pulse);
            n++;
            @(negedge clk);
        end
        clr_req = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        int            lat;
        int            n;
        logic          rdy_seen;
        logic [DW-1:0] got [$];
        int            t_first;
        int            t_last;

        // Reset held for three edges, then release and time the clear.
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_init_busy", init_busy, 1);
        check("rst_req_ready", req_ready, 0);
        rst_n = 1'b1;
        count_busy(-1, n, rdy_seen);
        check("clr_cycles", n, 16);
        check("clr_ready_low", rdy_seen, 0);
        check("idle_ready", req_ready, 1);

        for (int i = 0; i < 16; i++) begin
            do_read(i[AW-1:0], d, lat);
            check("clr_word", d, INIT);
            if (i == 0) check("rd_latency_first", lat, LAT);
        end

        // Byte enables: bytes 0 and 2 overwritten.
        do_write(4'd3, 32'h11223344, 4'b1111);
        do_write(4'd3, 32'hFFFFFFFF, 4'b0101);
        do_read(4'd3, d, lat);
        check("byte_en", d, 32'h11FF33FF);

        // Write then read next cycle; response after three edges, then hold.
        do_write(4'd5, 32'hDEADBEEF, 4'b1111);
        do_read(4'd5, d, lat);
        check("lat_cycles", lat, 3);
        check("lat_data", d, 32'hDEADBEEF);
        @(negedge clk);
        check("pulse_one_cycle", rsp_valid, 0);
        @(negedge clk);
        check("hold_data", data_out, 32'hDEADBEEF);

        // Back-to-back reads.
        do_write(4'd0, 32'd10, 4'b1111);
        do_write(4'd1, 32'd20, 4'b1111);
        do_write(4'd2, 32'd30, 4'b1111);
        t_first = -1;
        t_last  = -1;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid) begin
                got.push_back(data_out);
                if (t_first < 0) t_first = c;
                t_last = c;
            end
            if (c < 3) begin
                req_valid = 1'b1; rdn_wr = 1'b0; addr = c[AW-1:0];
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_count", got.size(), 3);
        check("b2b_first_cycle", t_first, 3);
        check("b2b_span", t_last - t_first, 2);
        for (int i = 0; i < 3; i++) begin
            check("b2b_data", (got.size() > i) ? got[i] : 32'hXXXXXXXX, 32'(10 * (i + 1)));
        end

        // Clear request collides with a write; second clr_req mid-clear is ignored.
        clr_req = 1'b1; req_valid = 1'b1; rdn_wr = 1'b1; addr = 4'd2; data_in = 32'd7; wbe = 4'hF;
        #1;
        check("coll_ready", req_ready, 0);
        @(negedge clk);
        clr_req = 1'b0; req_valid = 1'b0; rdn_wr = 1'b0; wbe = '0;
        count_busy(5, n, rdy_seen);
        check("coll_clr_cycles", n, 16);
        check("coll_ready_low", rdy_seen, 0);
        check("clr_keeps_data_out", data_out, 32'd30);
        do_read(4'd2, d, lat);
        check("coll_addr2", d, INIT);
        do_read(4'd0, d, lat);
        check("coll_addr0", d, INIT);

        // Reset pulse at clear cycle 9 restarts the full clear.
        do_write(4'd7, 32'h01020304, 4'b1111);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        n = 0;
        while (init_busy && n < 9) begin
            n++;
            @(negedge clk);
        end
        check("mid_busy_before_rst", init_busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_data_out", data_out, 0);
        count_busy(-1, n, rdy_seen);
        check("mid_rst_clr_cycles", n, 16);
        do_read(4'd7, d, lat);
        check("mid_rst_addr7", d, INIT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
